// File: rtl/altera_device_families.sv
// altera_device_families: registered device-family capability decoder.
// Maps a family code to capability flags, captured on inclock when inclocken=1.
//
// Ports:
//   inclock       in   clock; all registers update on its rising edge
//   aclr          in   asynchronous clear, active-high
//   inclocken     in   sample enable; registers hold when low
//   family_code   in   queried family code [CODE_W-1:0]
//   is_valid      out  code is a known family (1..18)
//   is_stratix    out  same as is_valid; includes the MAX families
//   is_stratixiii out  Stratix III-class (5,6,7,9,10,11)
//   is_maxii      out  MAX II-class (17,18)
//   has_inv_ddio  out  inverted output DDIO (13)
//   ddio_in_ok    out  is_stratix & ~is_maxii
//   err_sticky    out  an invalid code was sampled since the last aclr
//
// Build option: define ADF_ERR_STICKY_EN to build the sticky error register.
// Without it, err_sticky is tied to 0.
module altera_device_families #(
    parameter int CODE_W = 5
) (
    input  logic              inclock,
    input  logic              aclr,
    input  logic              inclocken,
    input  logic [CODE_W-1:0] family_code,
    output logic              is_valid,
    output logic              is_stratix,
    output logic              is_stratixiii,
    output logic              is_maxii,
    output logic              has_inv_ddio,
    output logic              ddio_in_ok,
    output logic              err_sticky
);

    logic w_valid;
    logic w_stratixiii;
    logic w_maxii;
    logic w_inv_ddio;

    logic r_valid;
    logic r_stratix;
    logic r_stratixiii;
    logic r_maxii;
    logic r_inv_ddio;
    logic r_ddio_in_ok;

    always_comb begin
        w_valid      = 1'b0;
        w_stratixiii = 1'b0;
        w_maxii      = 1'b0;
        w_inv_ddio   = 1'b0;
        case (family_code)
            5'd1, 5'd2, 5'd3, 5'd4,
            5'd8, 5'd12, 5'd14,
            5'd15, 5'd16: begin
                w_valid = 1'b1;
            end
            5'd5, 5'd6, 5'd7,
            5'd9, 5'd10, 5'd11: begin
                w_valid      = 1'b1;
                w_stratixiii = 1'b1;
            end
            5'd13: begin
                w_valid    = 1'b1;
                w_inv_ddio = 1'b1;
            end
            5'd17, 5'd18: begin
                w_valid = 1'b1;
                w_maxii = 1'b1;
            end
            default: begin
                w_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge inclock or posedge aclr) begin
        if (aclr) begin
            r_valid      <= 1'b0;
            r_stratix    <= 1'b0;
            r_stratixiii <= 1'b0;
            r_maxii      <= 1'b0;
            r_inv_ddio   <= 1'b0;
            r_ddio_in_ok <= 1'b0;
        end else if (inclocken) begin
            r_valid      <= w_valid;
            // Stratix-class covers every known family, MAX included.
            r_stratix    <= w_valid;
            r_stratixiii <= w_stratixiii;
            r_maxii      <= w_maxii;
            r_inv_ddio   <= w_inv_ddio;
            r_ddio_in_ok <= w_valid & ~w_maxii;
        end
    end

`ifdef ADF_ERR_STICKY_EN
    logic r_err_sticky;

    // Sets on any sampled invalid code; only aclr clears it.
    always_ff @(posedge inclock or posedge aclr) begin
        if (aclr) begin
            r_err_sticky <= 1'b0;
        end else if (inclocken && !w_valid) begin
            r_err_sticky <= 1'b1;
        end
    end

    assign err_sticky = r_err_sticky;
`else
    assign err_sticky = 1'b0;
`endif

    assign is_valid      = r_valid;
    assign is_stratix    = r_stratix;
    assign is_stratixiii = r_stratixiii;
    assign is_maxii      = r_maxii;
    assign has_inv_ddio  = r_inv_ddio;
    assign ddio_in_ok    = r_ddio_in_ok;

endmodule

// File: tb/tb_altera_device_families.sv
// tb_altera_device_families: directed scoreboard bench for the family decoder.
// Flags are packed {valid,stratix,iii,maxii,inv,ddio_in,err}.
module tb_altera_device_families;

    logic       inclock;
    logic       aclr;
    logic       inclocken;
    logic [4:0] family_code;
    logic       is_valid;
    logic       is_stratix;
    logic       is_stratixiii;
    logic       is_maxii;
    logic       has_inv_ddio;
    logic       ddio_in_ok;
    logic       err_sticky;

    int npass;
    int ntotal;
    logic [6:0] exp_reg;
    logic [6:0] sb[$];

    altera_device_families #(.CODE_W(5)) dut (
        .inclock       (inclock),
        .aclr          (aclr),
        .inclocken     (inclocken),
        .family_code   (family_code),
        .is_valid      (is_valid),
        .is_stratix    (is_stratix),
        .is_stratixiii (is_stratixiii),
        .is_maxii      (is_maxii),
        .has_inv_ddio  (has_inv_ddio),
        .ddio_in_ok    (ddio_in_ok),
        .err_sticky    (err_sticky)
    );

    initial inclock = 1'b0;
    always #5 inclock = ~inclock;

    function automatic logic [6:0] model(input logic [4:0] c,
                                         input logic prev_err);
        logic v, m, s3, inv, e;
        v   = (c inside {[5'd1:5'd18]});
        m   = (c inside {5'd17, 5'd18});
        s3  = (c inside {5'd5, 5'd6, 5'd7, 5'd9, 5'd10, 5'd11});
        inv = (c == 5'd13);
`ifdef ADF_ERR_STICKY_EN
        e = prev_err | ~v;
`else
        e = 1'b0;
`endif
        return {v, v, s3, m, inv, v & ~m, e};
    endfunction

    function automatic logic [6:0] observed();
        return {is_valid, is_stratix, is_stratixiii, is_maxii,
                has_inv_ddio, ddio_in_ok, err_sticky};
    endfunction

    task automatic check(input string tag, input logic [6:0] obs,
                         input logic [6:0] exp);
        ntotal++;
        assert (obs === exp) begin
            npass++;
        end else begin
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called at posedge+1: drives one query, checks it one edge later.
    task automatic step(input logic [4:0] c, input logic en);
        logic [6:0] e;
        family_code = c;
        inclocken   = en;
        if (en) exp_reg = model(c, exp_reg[0]);
        sb.push_back(exp_reg);
        @(posedge inclock);
        #1;
        e = sb.pop_front();
        check($sformatf("code%0d_en%0d", c, en), observed(), e);
    endtask

    initial begin
        npass       = 0;
        ntotal      = 0;
        exp_reg     = '0;
        aclr        = 1'b1;
        inclocken   = 1'b1;
        family_code = 5'd5;
        #2;
        check("aclr_hold", observed(), 7'd0);
        @(posedge inclock);
        #1;
        check("aclr_edge", observed(), 7'd0);
        aclr = 1'b0;

        step(5'd5, 1'b1);
        check("code5_flags", observed(), 7'b1110010);

        // Async clear mid-cycle, no edge needed.
        #2;
        aclr = 1'b1;
        #1;
        check("aclr_async", observed(), 7'd0);
        exp_reg = '0;
        aclr = 1'b0;
        @(posedge inclock);
        #1;

        for (int i = 0; i < 32; i++) step(5'(i), 1'b1);

        step(5'd12, 1'b1);
        for (int i = 0; i < 3; i++) step(5'd17, 1'b0);

        #2;
        aclr = 1'b1;
        #1;
        check("aclr_pre_sticky", observed(), 7'd0);
        exp_reg = '0;
        aclr = 1'b0;
        @(posedge inclock);
        #1;
        step(5'd25, 1'b1);
        step(5'd1, 1'b1);
        step(5'd1, 1'b1);
        #2;
        aclr = 1'b1;
        #1;
        check("sticky_clear", observed(), 7'd0);
        exp_reg = '0;
        aclr = 1'b0;
        @(posedge inclock);
        #1;

        step(5'd1, 1'b1);
        step(5'd17, 1'b1);
        step(5'd9, 1'b1);
        step(5'd0, 1'b1);

        // Clear held across an enabled edge wins over capture.
        family_code = 5'd5;
        inclocken   = 1'b1;
        #2;
        aclr = 1'b1;
        @(posedge inclock);
        #1;
        check("clear_wins", observed(), 7'd0);
        exp_reg = '0;
        aclr = 1'b0;
        step(5'd13, 1'b1);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
